// File: rtl/ocx_tlx_fifo_unload.sv
// Read-side unload stage for the TLX FIFO: 2-entry output buffer plus batched credit return.
// Optional parity check on RAM read data is enabled by defining OCX_TLX_FIFO_UNLOAD_PARITY_EN.
module ocx_tlx_fifo_unload #(
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int CREDIT_BATCH    = 4,
    parameter int CREDIT_TIMEOUT  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fifo_data_available,
    input  logic [DATA_WIDTH-1:0]      ram_rd_data,
`ifdef OCX_TLX_FIFO_UNLOAD_PARITY_EN
    input  logic                       ram_rd_par,
    output logic                       parity_error,
`endif
    output logic                       fifo_rd_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       credit_return_valid,
    output logic [FIFO_ADDR_WIDTH:0]   credit_return_cnt,
    output logic [FIFO_ADDR_WIDTH:0]   pending_credits
);

    localparam int CW = FIFO_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_CREDITS  = CW'(2 ** FIFO_ADDR_WIDTH);
    localparam logic [CW-1:0] BATCH        = CW'(CREDIT_BATCH);
    localparam logic [7:0]    TIMEOUT_LAST = 8'(CREDIT_TIMEOUT - 1);

    typedef enum logic {S_ACCUM = 1'b0, S_RETURN = 1'b1} state_t;

    logic [1:0]            r_buf_cnt;
    logic                  r_buf_full;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_slot0;
    logic [DATA_WIDTH-1:0] r_slot1;
    state_t                r_state;
    logic [CW-1:0]         r_pending;
    logic [7:0]            r_timer;
    logic                  r_crv;
    logic [CW-1:0]         r_crc;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_buf_cnt_d;
    logic [CW-1:0]         w_pending_inc;
    logic                  w_return;

    // Read decision uses only the registered full flag, so out_ready never reaches fifo_rd_done.
    assign w_push        = fifo_data_available && !r_buf_full && !reset;
    assign w_pop         = r_out_valid && out_ready;
    assign w_buf_cnt_d   = r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
    assign w_pending_inc = (w_push && (r_pending != MAX_CREDITS)) ? r_pending + CW'(1) : r_pending;
    assign w_return      = (r_state == S_ACCUM) &&
                           ((r_pending >= BATCH) || ((r_pending != '0) && (r_timer == TIMEOUT_LAST)));

    assign fifo_rd_done        = w_push;
    assign out_valid           = r_out_valid;
    assign out_data            = r_slot0;
    assign credit_return_valid = r_crv;
    assign credit_return_cnt   = r_crc;
    assign pending_credits     = r_pending;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_cnt   <= 2'd0;
            r_buf_full  <= 1'b0;
            r_out_valid <= 1'b0;
            r_slot0     <= '0;
            r_slot1     <= '0;
        end else begin
            r_buf_cnt   <= w_buf_cnt_d;
            r_buf_full  <= (w_buf_cnt_d == 2'd2);
            r_out_valid <= (w_buf_cnt_d != 2'd0);
            if (w_pop) begin
                if (r_buf_cnt == 2'd2)
                    r_slot0 <= r_slot1;
                else if (w_push)
                    r_slot0 <= ram_rd_data;
            end else if (w_push) begin
                if (r_buf_cnt == 2'd0)
                    r_slot0 <= ram_rd_data;
                else
                    r_slot1 <= ram_rd_data;
            end
        end
    end

    // The return pulse and the pending reload share one edge; a concurrent rd_done seeds the new count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_ACCUM;
            r_pending <= '0;
            r_timer   <= 8'd0;
            r_crv     <= 1'b0;
            r_crc     <= '0;
        end else begin
            r_crv <= 1'b0;
            r_crc <= '0;
            case (r_state)
                S_ACCUM: begin
                    if (w_return) begin
                        r_state   <= S_RETURN;
                        r_crv     <= 1'b1;
                        r_crc     <= r_pending;
                        r_pending <= w_push ? CW'(1) : '0;
                        r_timer   <= 8'd0;
                    end else begin
                        r_pending <= w_pending_inc;
                        r_timer   <= (r_pending == '0) ? 8'd0 : r_timer + 8'd1;
                    end
                end
                S_RETURN: begin
                    r_state   <= S_ACCUM;
                    r_pending <= w_pending_inc;
                    r_timer   <= 8'd0;
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

`ifdef OCX_TLX_FIFO_UNLOAD_PARITY_EN
    logic r_parity_error;

    always_ff @(posedge clock) begin
        if (reset)
            r_parity_error <= 1'b0;
        else if (w_push && (^{ram_rd_data, ram_rd_par}))
            r_parity_error <= 1'b1;
    end

    assign parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_ocx_tlx_fifo_unload.sv
// Directed-vector bench for ocx_tlx_fifo_unload: table rows plus timeout, reset and random credit-conservation sequences.
module tb_ocx_tlx_fifo_unload;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int CW = AW + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          avail;
    logic [DW-1:0] data;
    logic          ready;
    logic          fifo_rd_done;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          credit_return_valid;
    logic [CW-1:0] credit_return_cnt;
    logic [CW-1:0] pending_credits;
`ifdef OCX_TLX_FIFO_UNLOAD_PARITY_EN
    logic          par_flip = 1'b0;
    logic          ram_rd_par;
    logic          parity_error;
    assign ram_rd_par = (^data) ^ par_flip;
`endif

    always #5 clock = ~clock;

    ocx_tlx_fifo_unload #(
        .FIFO_ADDR_WIDTH(AW),
        .DATA_WIDTH     (DW),
        .CREDIT_BATCH   (4),
        .CREDIT_TIMEOUT (8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .fifo_data_available(avail),
        .ram_rd_data        (data),
`ifdef OCX_TLX_FIFO_UNLOAD_PARITY_EN
        .ram_rd_par         (ram_rd_par),
        .parity_error       (parity_error),
`endif
        .fifo_rd_done       (fifo_rd_done),
        .out_valid          (out_valid),
        .out_ready          (ready),
        .out_data           (out_data),
        .credit_return_valid(credit_return_valid),
        .credit_return_cnt  (credit_return_cnt),
        .pending_credits    (pending_credits)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
    task automatic drive(input logic r, input logic a, input logic [63:0] d, input logic rd);
        @(negedge clock);
        reset = r;
        avail = a;
        data  = d;
        ready = rd;
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic          av;
        logic [63:0]   d;
        logic          rdy;
        logic          e_rd;
        logic          e_ov;
        logic          chk_d;
        logic [63:0]   e_od;
        logic          chk_c;
        logic          e_crv;
        logic [CW-1:0] e_crc;
        logic [CW-1:0] e_pend;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic av, input logic [63:0] d, input logic rdy,
                               input logic e_rd, input logic e_ov, input logic chk_d, input logic [63:0] e_od,
                               input logic chk_c, input logic e_crv, input logic [CW-1:0] e_crc,
                               input logic [CW-1:0] e_pend);
        vec_t t;
        t.rst = rst;   t.av = av;       t.d = d;         t.rdy = rdy;
        t.e_rd = e_rd; t.e_ov = e_ov;   t.chk_d = chk_d; t.e_od = e_od;
        t.chk_c = chk_c; t.e_crv = e_crv; t.e_crc = e_crc; t.e_pend = e_pend;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          tbl[$];
        logic [63:0]   q[$];
        int unsigned   rd_sum;
        int unsigned   ret_sum;
        int            k;
        logic          found;
        logic          bad_pulse;
        logic          exp_rd;

        reset = 1'b1; avail = 1'b0; data = '0; ready = 1'b0;
        repeat (2) @(negedge clock);

        // Reset with avail high, release, streaming of 8 entries, two batched returns.
        tbl.push_back(v(1, 1, 0, 1,   0, 0, 1, 0,   1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1,   1, 0, 1, 0,   1, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 1,   1, 1, 1, 1,   1, 0, 0, 1));
        tbl.push_back(v(0, 1, 3, 1,   1, 1, 1, 2,   1, 0, 0, 2));
        tbl.push_back(v(0, 1, 4, 1,   1, 1, 1, 3,   1, 0, 0, 3));
        tbl.push_back(v(0, 1, 5, 1,   1, 1, 1, 4,   1, 0, 0, 4));
        tbl.push_back(v(0, 1, 6, 1,   1, 1, 1, 5,   1, 1, 4, 1));
        tbl.push_back(v(0, 1, 7, 1,   1, 1, 1, 6,   1, 0, 0, 2));
        tbl.push_back(v(0, 1, 8, 1,   1, 1, 1, 7,   1, 0, 0, 3));
        tbl.push_back(v(0, 0, 0, 1,   0, 1, 1, 8,   1, 0, 0, 4));
        tbl.push_back(v(0, 0, 0, 1,   0, 0, 0, 0,   1, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 1,   0, 0, 0, 0,   1, 0, 0, 0));
        // Backpressure: two reads fill the buffer, reads stop, head holds, then drain in order.
        tbl.push_back(v(1, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h11,  0, 1, 0, 1, 0,     1, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h22,  0, 1, 1, 1, 'h11,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h33,  0, 0, 1, 1, 'h11,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h33,  0, 0, 1, 1, 'h11,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h33,  1, 0, 1, 1, 'h11,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h33,  1, 1, 1, 1, 'h22,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h44,  1, 1, 1, 1, 'h33,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,     1, 0, 1, 1, 'h44,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].d, tbl[i].rdy);
            check($sformatf("row%0d rd_done", i), 64'(fifo_rd_done), 64'(tbl[i].e_rd));
            check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].chk_d)
                check($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
            if (tbl[i].chk_c) begin
                check($sformatf("row%0d crv", i), 64'(credit_return_valid), 64'(tbl[i].e_crv));
                check($sformatf("row%0d crc", i), 64'(credit_return_cnt), 64'(tbl[i].e_crc));
                check($sformatf("row%0d pending", i), 64'(pending_credits), 64'(tbl[i].e_pend));
            end
        end

        // Single entry then idle: return of 1 exactly 8 cycles after pending becomes 1.
        drive(1, 0, 0, 1);
        drive(0, 1, 'h55, 1);
        check("timeout rd_done", 64'(fifo_rd_done), 64'd1);
        drive(0, 0, 0, 1);
        check("timeout pending1", 64'(pending_credits), 64'd1);
        check("timeout no early pulse", 64'(credit_return_valid), 64'd0);
        found = 1'b0;
        k = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            drive(0, 0, 0, 1);
            if (credit_return_valid) begin
                found = 1'b1;
                k = c;
            end
        end
        check("timeout latency", 64'(k), 64'd8);
        check("timeout cnt", 64'(credit_return_cnt), 64'd1);
        drive(0, 0, 0, 1);
        check("timeout after pulse", 64'(credit_return_valid), 64'd0);
        check("timeout pending cleared", 64'(pending_credits), 64'd0);

        // Reset with one pending credit discards it without any return pulse.
        drive(0, 1, 'h66, 1);
        repeat (3) drive(0, 0, 0, 1);
        check("pre-reset pending", 64'(pending_credits), 64'd1);
        drive(1, 0, 0, 1);
        bad_pulse = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 1);
            if (credit_return_valid) bad_pulse = 1'b1;
        end
        check("reset discard pulse", 64'(bad_pulse), 64'd0);
        check("reset discard pending", 64'(pending_credits), 64'd0);

        // Random traffic against a queue model; returned credits must equal reads.
        drive(1, 0, 0, 0);
        rd_sum  = 0;
        ret_sum = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(0, ($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            exp_rd = avail && (q.size() < 2);
            check($sformatf("rand%0d rd_done", c), 64'(fifo_rd_done), 64'(exp_rd));
            check($sformatf("rand%0d out_valid", c), 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0)
                check($sformatf("rand%0d out_data", c), out_data, q[0]);
            if (credit_return_valid) ret_sum += credit_return_cnt;
            if ((q.size() != 0) && ready) void'(q.pop_front());
            if (exp_rd) begin
                q.push_back(data);
                rd_sum++;
            end
        end
        for (int c = 0; c < 60; c++) begin
            drive(0, 0, 0, 1);
            if (credit_return_valid) ret_sum += credit_return_cnt;
        end
        check("credit conservation", 64'(ret_sum), 64'(rd_sum));
        check("drain pending zero", 64'(pending_credits), 64'd0);

`ifdef OCX_TLX_FIFO_UNLOAD_PARITY_EN
        // Bad parity on entry 3 sets a sticky error the following cycle.
        drive(1, 0, 0, 1);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clock);
            reset = 1'b0; avail = 1'b1; data = 64'(e); ready = 1'b1;
            par_flip = (e == 3);
            #1;
            check($sformatf("parity entry%0d", e), 64'(parity_error), 64'(e > 3));
        end
        par_flip = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 1);
            check($sformatf("parity sticky%0d", c), 64'(parity_error), 64'd1);
        end
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("parity cleared by reset", 64'(parity_error), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
